// File: rtl/fp_mul_arbiter_pkg.sv
// Shared types and constants for the round-robin arbiter in front of the serial FP multiplier.
package fp_mul_arbiter_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOADA = 3'd1,
    ST_LOADB = 3'd2,
    ST_WAIT  = 3'd3,
    ST_RESP  = 3'd4
  } state_t;

  localparam int          STATE_W     = 3;
  localparam logic [31:0] QNAN        = 32'h7FC0_0000;
  localparam int          DEF_NREQ    = 4;
  localparam int          DEF_TIMEOUT = 64;

endpackage

// File: rtl/fp_mul_arbiter_rr_picker.sv
// Combinational round-robin search: first set request bit at or after ptr, wrapping to 0.
module rr_picker #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic            found,
  output logic [IDW-1:0]  idx
);

  always_comb begin : search
    int pos;
    found = 1'b0;
    idx   = '0;
    pos   = 0;
    for (int off = 0; off < NREQ; off++) begin
      pos = int'(ptr) + off;
      if (pos >= NREQ) pos = pos - NREQ;
      if (!found && req[pos]) begin
        found = 1'b1;
        idx   = IDW'(pos);
      end
    end
  end

endmodule

// File: rtl/fp_mul_arbiter.sv
// Shares one serial FP multiplier among NREQ requesters: round-robin grant, A/B operand
// serialisation, bounded wait for the product, and a held per-requester response.
module fp_mul_arbiter
  import fp_mul_arbiter_pkg::*;
#(
  parameter int  NREQ    = DEF_NREQ,
  parameter int  TIMEOUT = DEF_TIMEOUT,
  localparam int IDW     = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ*32-1:0]   req_a,
  input  logic [NREQ*32-1:0]   req_b,
  output logic [NREQ-1:0]      req_ready,
  output logic [NREQ-1:0]      rsp_valid,
  input  logic [NREQ-1:0]      rsp_ready,
  output logic [31:0]          rsp_product,
  output logic                 rsp_error,
  output logic                 mul_start,
  output logic [31:0]          mul_operand,
  input  logic                 mul_done,
  input  logic [31:0]          mul_product,
  output logic                 busy,
  output logic [IDW-1:0]       grant_id,
  output logic [STATE_W-1:0]   fsm_state
);

  localparam int CW = $clog2(TIMEOUT + 1);

  state_t          state;
  logic [IDW-1:0]  rr_ptr;
  logic [CW-1:0]   wait_cnt;
  logic [31:0]     b_lat;
  logic            pick_found;
  logic [IDW-1:0]  pick_idx;
  logic [NREQ-1:0] pick_oh;
  logic [NREQ-1:0] grant_oh;

  rr_picker #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_picker (
    .req   (req_valid),
    .ptr   (rr_ptr),
    .found (pick_found),
    .idx   (pick_idx)
  );

  assign pick_oh   = NREQ'(1) << pick_idx;
  assign grant_oh  = NREQ'(1) << grant_id;
  assign fsm_state = state;

  // Request handshake: a transfer happens on the rising edge where req_valid[i] and
  // req_ready[i] are both high; req_ready is offered only in IDLE, only to the picked
  // requester. Response handshake: rsp_valid[g] holds until rsp_ready[g] is seen high.
  assign req_ready = (state == ST_IDLE && !reset && pick_found) ? pick_oh : '0;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      rr_ptr      <= '0;
      grant_id    <= '0;
      wait_cnt    <= '0;
      b_lat       <= '0;
      mul_start   <= 1'b0;
      mul_operand <= '0;
      rsp_valid   <= '0;
      rsp_product <= '0;
      rsp_error   <= 1'b0;
      busy        <= 1'b0;
    end else begin
      mul_start <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (pick_found) begin
            grant_id    <= pick_idx;
            b_lat       <= req_b[32*int'(pick_idx) +: 32];
            mul_operand <= req_a[32*int'(pick_idx) +: 32];
            mul_start   <= 1'b1;
            busy        <= 1'b1;
            state       <= ST_LOADA;
          end
        end
        ST_LOADA: begin
          mul_operand <= b_lat;
          state       <= ST_LOADB;
        end
        ST_LOADB: begin
          mul_operand <= '0;
          wait_cnt    <= '0;
          state       <= ST_WAIT;
        end
        ST_WAIT: begin
          // A product arriving on the last allowed cycle still beats the timeout.
          if (mul_done) begin
            rsp_product <= mul_product;
            rsp_error   <= 1'b0;
            rsp_valid   <= grant_oh;
            state       <= ST_RESP;
          end else if (wait_cnt == CW'(TIMEOUT - 1)) begin
            rsp_product <= QNAN;
            rsp_error   <= 1'b1;
            rsp_valid   <= grant_oh;
            wait_cnt    <= wait_cnt + 1'b1;
            state       <= ST_RESP;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        ST_RESP: begin
          if (rsp_ready[grant_id]) begin
            rsp_valid   <= '0;
            rsp_product <= '0;
            rsp_error   <= 1'b0;
            busy        <= 1'b0;
            rr_ptr      <= (grant_id == IDW'(NREQ - 1)) ? '0 : grant_id + 1'b1;
            state       <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_mul_arbiter.sv
// Directed, table-driven bench for fp_mul_arbiter with a hand-scripted multiplier model.
module tb_fp_mul_arbiter;
  import fp_mul_arbiter_pkg::*;

  localparam int NREQ    = 4;
  localparam int TIMEOUT = 64;
  localparam int IDW     = 2;

  logic               clock;
  logic               reset;
  logic [NREQ-1:0]    req_valid;
  logic [NREQ*32-1:0] req_a;
  logic [NREQ*32-1:0] req_b;
  logic [NREQ-1:0]    req_ready;
  logic [NREQ-1:0]    rsp_valid;
  logic [NREQ-1:0]    rsp_ready;
  logic [31:0]        rsp_product;
  logic               rsp_error;
  logic               mul_start;
  logic [31:0]        mul_operand;
  logic               mul_done;
  logic [31:0]        mul_product;
  logic               busy;
  logic [IDW-1:0]     grant_id;
  logic [STATE_W-1:0] fsm_state;

  int checks = 0;
  int errors = 0;

  fp_mul_arbiter #(.NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
    .clock       (clock),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_a       (req_a),
    .req_b       (req_b),
    .req_ready   (req_ready),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_product (rsp_product),
    .rsp_error   (rsp_error),
    .mul_start   (mul_start),
    .mul_operand (mul_operand),
    .mul_done    (mul_done),
    .mul_product (mul_product),
    .busy        (busy),
    .grant_id    (grant_id),
    .fsm_state   (fsm_state)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    int          id;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] prod;
    int          done_at;
    bit          early;
    logic [31:0] exp_prod;
    logic        exp_err;
    int          exp_wait;
  } vec_t;

  vec_t vecs[5];
  logic [31:0] rr_b[4];
  logic [31:0] rr_p[4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic set_operands(input int id, input logic [31:0] a, input logic [31:0] b);
    req_a[32*id +: 32] = a;
    req_b[32*id +: 32] = b;
  endtask

  // One full transaction starting in IDLE. mask != onehot(id) keeps req_valid held.
  task automatic run_op(input int id, input logic [NREQ-1:0] mask,
                        input logic [31:0] a, input logic [31:0] b, input logic [31:0] prod,
                        input int done_at, input bit early, input int stall,
                        input logic [31:0] exp_prod, input logic exp_err, input int exp_wait);
    logic [NREQ-1:0] oh;
    bit hold;
    bit got;
    int waited;
    oh   = NREQ'(1) << id;
    hold = (mask != oh);
    req_valid = mask;
    set_operands(id, a, b);
    #1;
    check("req_ready_grant", 32'(req_ready), 32'(oh));
    step();
    if (!hold) begin
      req_valid = '0;
      set_operands(id, $urandom, $urandom);
    end
    check("mul_start_loada", 32'(mul_start), 32'd1);
    check("operand_a", mul_operand, a);
    check("grant_id", 32'(grant_id), 32'(id));
    check("busy", 32'(busy), 32'd1);
    check("req_ready_quiet", 32'(req_ready), 32'd0);
    step();
    check("mul_start_loadb", 32'(mul_start), 32'd0);
    check("operand_b", mul_operand, b);
    if (early) begin
      mul_done    = 1'b1;
      mul_product = 32'hBAD0_BAD0;
    end
    step();
    mul_done    = 1'b0;
    mul_product = '0;
    check("operand_idle", mul_operand, 32'd0);
    check("state_wait", 32'(fsm_state), 32'(ST_WAIT));
    got    = 1'b0;
    waited = 0;
    for (int k = 0; k < TIMEOUT + 8 && !got; k++) begin
      if (k == done_at) begin
        mul_done    = 1'b1;
        mul_product = prod;
      end
      step();
      mul_done    = 1'b0;
      mul_product = '0;
      waited++;
      if (rsp_valid != '0) got = 1'b1;
    end
    check("rsp_seen", 32'(got), 32'd1);
    check("wait_cycles", 32'(waited), 32'(exp_wait));
    check("rsp_valid", 32'(rsp_valid), 32'(oh));
    check("rsp_product", rsp_product, exp_prod);
    check("rsp_error", 32'(rsp_error), 32'(exp_err));
    for (int s = 0; s < stall; s++) begin
      req_valid = '1;
      rsp_ready = ~oh;
      step();
      check("stall_rsp_valid", 32'(rsp_valid), 32'(oh));
      check("stall_product", rsp_product, exp_prod);
      check("stall_req_ready", 32'(req_ready), 32'd0);
    end
    req_valid = hold ? mask : '0;
    rsp_ready = oh;
    step();
    rsp_ready = '0;
    check("rsp_drop", 32'(rsp_valid), 32'd0);
    check("busy_drop", 32'(busy), 32'd0);
  endtask

  initial begin
    // 3*2=6, 0.5*10=5, -2*3=-6, timeout, 1*1=1 on the last allowed WAIT cycle
    vecs[0] = '{0, 32'h4040_0000, 32'h4000_0000, 32'h40C0_0000, 0,    1'b0, 32'h40C0_0000, 1'b0, 1};
    vecs[1] = '{1, 32'h3F00_0000, 32'h4120_0000, 32'h40A0_0000, 3,    1'b0, 32'h40A0_0000, 1'b0, 4};
    vecs[2] = '{2, 32'hC000_0000, 32'h4040_0000, 32'hC0C0_0000, 10,   1'b1, 32'hC0C0_0000, 1'b0, 11};
    vecs[3] = '{3, 32'h4000_0000, 32'h4000_0000, 32'h4080_0000, 1000, 1'b0, QNAN,          1'b1, TIMEOUT};
    vecs[4] = '{0, 32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000, TIMEOUT - 1, 1'b0, 32'h3F80_0000, 1'b0, TIMEOUT};
    rr_b = '{32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 32'h4080_0000};
    rr_p = '{32'h4000_0000, 32'h4080_0000, 32'h40C0_0000, 32'h4100_0000};

    reset       = 1'b1;
    req_valid   = '0;
    req_a       = '0;
    req_b       = '0;
    rsp_ready   = '0;
    mul_done    = 1'b0;
    mul_product = '0;
    repeat (2) @(posedge clock);
    #1;
    check("rst_state", 32'(fsm_state), 32'(ST_IDLE));
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_operand", mul_operand, 32'd0);
    check("rst_grant_id", 32'(grant_id), 32'd0);
    reset = 1'b0;
    step();

    // all four held high: grants 0,1,2,3 then wrap to 0
    for (int i = 0; i < NREQ; i++) set_operands(i, 32'h4000_0000, rr_b[i]);
    for (int n = 0; n < 5; n++)
      run_op(n % 4, 4'hF, 32'h4000_0000, rr_b[n % 4], rr_p[n % 4], 0, 1'b0, 0,
             rr_p[n % 4], 1'b0, 1);
    req_valid = '0;
    step();

    for (int v = 0; v < 5; v++)
      run_op(vecs[v].id, NREQ'(1) << vecs[v].id, vecs[v].a, vecs[v].b, vecs[v].prod,
             vecs[v].done_at, vecs[v].early, 0, vecs[v].exp_prod, vecs[v].exp_err,
             vecs[v].exp_wait);

    // response held for 10 cycles with competing requests and foreign rsp_ready bits
    run_op(3, 4'b1000, 32'h4080_0000, 32'h4080_0000, 32'h4180_0000, 1, 1'b0, 10,
           32'h4180_0000, 1'b0, 2);

    // leave rr_ptr at 2, then abandon an op on requester 2 with a reset in WAIT
    run_op(1, 4'b0010, 32'h4040_0000, 32'h4040_0000, 32'h4110_0000, 0, 1'b0, 0,
           32'h4110_0000, 1'b0, 1);
    req_valid = 4'b0100;
    set_operands(2, 32'h4000_0000, 32'h4000_0000);
    #1;
    check("pre_rst_grant", 32'(req_ready), 32'b0100);
    step();
    req_valid = '0;
    repeat (3) step();
    check("pre_rst_wait", 32'(fsm_state), 32'(ST_WAIT));
    #1;
    reset = 1'b1;
    #1;
    check("midrst_state", 32'(fsm_state), 32'(ST_IDLE));
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_grant_id", 32'(grant_id), 32'd0);
    @(posedge clock);
    #1;
    reset       = 1'b0;
    mul_done    = 1'b1;
    mul_product = 32'h4080_0000;
    step();
    mul_done    = 1'b0;
    mul_product = '0;
    check("late_done_rsp", 32'(rsp_valid), 32'd0);
    check("late_done_state", 32'(fsm_state), 32'(ST_IDLE));
    step();
    check("late_done_hold", 32'(rsp_valid), 32'd0);
    for (int i = 0; i < NREQ; i++) set_operands(i, 32'h4000_0000, rr_b[i]);
    run_op(0, 4'hF, 32'h4000_0000, rr_b[0], rr_p[0], 0, 1'b0, 0, rr_p[0], 1'b0, 1);
    req_valid = '0;
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
